// File: rtl/masked_sbox_serial_ctrl.sv
// Serial nibble sequencer for a shared three-share masked S-box stage.
// Macro PRNG_EN swaps the external `fresh` randomness for an internal 8-bit LFSR.
module masked_sbox_serial_ctrl #(
    parameter int unsigned LAT  = 1,
    parameter logic [7:0]  SEED = 8'hA5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [63:0] state_in1,
    input  logic [63:0] state_in2,
    input  logic [63:0] state_in3,
`ifndef PRNG_EN
    input  logic [7:0]  fresh,
`endif
    input  logic [3:0]  sb_out1,
    input  logic [3:0]  sb_out2,
    input  logic [3:0]  sb_out3,
    output logic        busy,
    output logic        done,
    output logic [63:0] state_out1,
    output logic [63:0] state_out2,
    output logic [63:0] state_out3,
    output logic [3:0]  sb_in1,
    output logic [3:0]  sb_in2,
    output logic [3:0]  sb_in3,
    output logic [7:0]  sb_r
);

    if (LAT < 1 || LAT > 3) begin : g_bad_lat
        $error("LAT must be in 1..3");
    end
    if (SEED == 8'h00) begin : g_bad_seed
        $error("SEED must be nonzero");
    end

    typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

    state_t         state;
    logic [63:0]    sh1, sh2, sh3;
    logic [3:0]     fc, cc;
    logic [LAT-1:0] vld;
    logic           in_feed;
    logic           capture;

    assign in_feed = (state == FEED);
    // The valid pipe mirrors the stage latency; its tail marks a returning nibble.
    assign capture = vld[LAT-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sh1        <= '0;
            sh2        <= '0;
            sh3        <= '0;
            fc         <= '0;
            cc         <= '0;
            vld        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            state_out1 <= '0;
            state_out2 <= '0;
            state_out3 <= '0;
        end else begin
            vld <= LAT'({vld, in_feed});
            case (state)
                IDLE: begin
                    if (start) begin
                        sh1   <= state_in1;
                        sh2   <= state_in2;
                        sh3   <= state_in3;
                        fc    <= '0;
                        cc    <= '0;
                        busy  <= 1'b1;
                        state <= FEED;
                    end
                end
                FEED: begin
                    sh1 <= sh1 >> 4;
                    sh2 <= sh2 >> 4;
                    sh3 <= sh3 >> 4;
                    if (fc == 4'hF) state <= DRAIN;
                    else            fc    <= fc + 4'd1;
                end
                DRAIN: begin
                    if (capture && cc == 4'hF) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if (capture) begin
                state_out1[{cc, 2'b00} +: 4] <= sb_out1;
                state_out2[{cc, 2'b00} +: 4] <= sb_out2;
                state_out3[{cc, 2'b00} +: 4] <= sb_out3;
                if (cc != 4'hF) cc <= cc + 4'd1;
            end
        end
    end

    always_comb begin
        sb_in1 = '0;
        sb_in2 = '0;
        sb_in3 = '0;
        if (in_feed) begin
            sb_in1 = sh1[3:0];
            sb_in2 = sh2[3:0];
            sb_in3 = sh3[3:0];
        end
    end

`ifdef PRNG_EN
    logic [7:0] lfsr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       lfsr <= SEED;
        else if (in_feed) lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

    assign sb_r = in_feed ? lfsr : '0;
`else
    assign sb_r = in_feed ? fresh : '0;
`endif

endmodule

// File: tb/tb_masked_sbox_serial_ctrl.sv
// Bench for masked_sbox_serial_ctrl: LAT=1 and LAT=3 instances driven in lockstep,
// each attached to a behavioural masked PRINCE S-box stage of matching latency.
module tb_masked_sbox_serial_ctrl;

    localparam int NV = 6;
    localparam logic [63:0] SBOX_TBL = 64'h4D5E087619CA23FB;

    typedef struct packed {
        logic [63:0]  in1, in2, in3;
        logic [127:0] rnd;
        logic         inject;
        logic [63:0]  e1, e2, e3;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [63:0] in1 = '0, in2 = '0, in3 = '0;
    logic [7:0]  fresh = 8'h00;

    logic        a_busy, a_done, b_busy, b_done;
    logic [63:0] a_o1, a_o2, a_o3, b_o1, b_o2, b_o3;
    logic [3:0]  a_si1, a_si2, a_si3, a_so1, a_so2, a_so3;
    logic [3:0]  b_si1, b_si2, b_si3, b_so1, b_so2, b_so3;
    logic [7:0]  a_r, b_r;

    int unsigned n_vec = 0, n_bad = 0;
    logic [63:0] prev1 = '0;
    logic [7:0]  lfsr_m = 8'hA5;
    vec_t        vt [NV];

    always #5 clk = ~clk;

    masked_sbox_serial_ctrl #(.LAT(1), .SEED(8'hA5)) u_lat1 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .state_in1(in1), .state_in2(in2), .state_in3(in3),
`ifndef PRNG_EN
        .fresh(fresh),
`endif
        .sb_out1(a_so1), .sb_out2(a_so2), .sb_out3(a_so3),
        .busy(a_busy), .done(a_done),
        .state_out1(a_o1), .state_out2(a_o2), .state_out3(a_o3),
        .sb_in1(a_si1), .sb_in2(a_si2), .sb_in3(a_si3), .sb_r(a_r)
    );

    masked_sbox_serial_ctrl #(.LAT(3), .SEED(8'hA5)) u_lat3 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .state_in1(in1), .state_in2(in2), .state_in3(in3),
`ifndef PRNG_EN
        .fresh(fresh),
`endif
        .sb_out1(b_so1), .sb_out2(b_so2), .sb_out3(b_so3),
        .busy(b_busy), .done(b_done),
        .state_out1(b_o1), .state_out2(b_o2), .state_out3(b_o3),
        .sb_in1(b_si1), .sb_in2(b_si2), .sb_in3(b_si3), .sb_r(b_r)
    );

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [63:0] t;
        t = SBOX_TBL;
        return t[4*x +: 4];
    endfunction

    // Stage model: output shares XOR to S(x); shares 2/3 carry the remask bits.
    function automatic logic [11:0] stage(input logic [3:0] x1, x2, x3, input logic [7:0] r);
        logic [3:0] o1, o2, o3;
        o2 = x2 ^ r[3:0];
        o3 = x3 ^ r[7:4];
        o1 = sbox(x1 ^ x2 ^ x3) ^ o2 ^ o3;
        return {o3, o2, o1};
    endfunction

    function automatic logic [191:0] run_model(input logic [63:0] s1, s2, s3, input logic [127:0] rnd);
        logic [63:0] o1, o2, o3;
        logic [11:0] y;
        for (int i = 0; i < 16; i++) begin
            y = stage(s1[4*i +: 4], s2[4*i +: 4], s3[4*i +: 4], rnd[8*i +: 8]);
            o1[4*i +: 4] = y[3:0];
            o2[4*i +: 4] = y[7:4];
            o3[4*i +: 4] = y[11:8];
        end
        return {o3, o2, o1};
    endfunction

    function automatic logic [63:0] sbox64(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 16; i++) y[4*i +: 4] = sbox(x[4*i +: 4]);
        return y;
    endfunction

    function automatic logic [7:0] lfsr_step(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    logic [11:0] pa;
    logic [11:0] pb [3];
    always @(posedge clk) begin
        pa    <= stage(a_si1, a_si2, a_si3, a_r);
        pb[0] <= stage(b_si1, b_si2, b_si3, b_r);
        pb[1] <= pb[0];
        pb[2] <= pb[1];
    end
    assign {a_so3, a_so2, a_so1} = pa;
    assign {b_so3, b_so2, b_so1} = pb[2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " busy_a"}, a_busy, 0);
        chk({tag, " done_a"}, a_done, 0);
        chk({tag, " busy_b"}, b_busy, 0);
        chk({tag, " done_b"}, b_done, 0);
        chk({tag, " out_a"}, a_o1 | a_o2 | a_o3, 0);
        chk({tag, " out_b"}, b_o1 | b_o2 | b_o3, 0);
        chk({tag, " sb_in"}, {a_si1, a_si2, a_si3, b_si1, b_si2, b_si3}, 0);
        chk({tag, " sb_r"}, {a_r, b_r}, 0);
    endtask

    task automatic run_op(input vec_t v, input int id);
        logic [127:0] rnd;
        logic [191:0] e;
        logic [7:0]   r_exp;
        logic [11:0]  nib_exp;
        rnd = v.rnd;
`ifdef PRNG_EN
        for (int i = 0; i < 16; i++) begin
            rnd[8*i +: 8] = lfsr_m;
            lfsr_m = lfsr_step(lfsr_m);
        end
        e = run_model(v.in1, v.in2, v.in3, rnd);
`else
        e = {v.e3, v.e2, v.e1};
`endif
        @(negedge clk);
        start = 1'b1;
        in1 = v.in1; in2 = v.in2; in3 = v.in3;
        fresh = 8'($urandom);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            start = (v.inject && (c == 5 || c == 18));
            in1 = {$urandom, $urandom}; in2 = {$urandom, $urandom}; in3 = {$urandom, $urandom};
            r_exp = 8'h00;
            nib_exp = 12'h000;
            if (c <= 16) begin
                r_exp = rnd[8*(c-1) +: 8];
                nib_exp = {v.in1[4*(c-1) +: 4], v.in2[4*(c-1) +: 4], v.in3[4*(c-1) +: 4]};
            end
`ifdef PRNG_EN
            fresh = 8'($urandom);
`else
            fresh = (c <= 16) ? r_exp : 8'($urandom);
`endif
            #1;
            chk($sformatf("v%0d c%0d busy_a", id, c), a_busy, c <= 18);
            chk($sformatf("v%0d c%0d done_a", id, c), a_done, c == 18);
            chk($sformatf("v%0d c%0d busy_b", id, c), b_busy, c <= 20);
            chk($sformatf("v%0d c%0d done_b", id, c), b_done, c == 20);
            chk($sformatf("v%0d c%0d sb_r_a", id, c), a_r, r_exp);
            chk($sformatf("v%0d c%0d sb_r_b", id, c), b_r, r_exp);
            chk($sformatf("v%0d c%0d sb_in_a", id, c), {a_si1, a_si2, a_si3}, nib_exp);
            chk($sformatf("v%0d c%0d sb_in_b", id, c), {b_si1, b_si2, b_si3}, nib_exp);
            if (c == 2) chk($sformatf("v%0d nib0_a_old", id), a_o1[3:0], prev1[3:0]);
            if (c == 3) chk($sformatf("v%0d nib0_a_new", id), a_o1[3:0], e[3:0]);
            if (c == 4) chk($sformatf("v%0d nib0_b_old", id), b_o1[3:0], prev1[3:0]);
            if (c == 5) chk($sformatf("v%0d nib0_b_new", id), b_o1[3:0], e[3:0]);
        end
        chk($sformatf("v%0d out1_a", id), a_o1, e[63:0]);
        chk($sformatf("v%0d out2_a", id), a_o2, e[127:64]);
        chk($sformatf("v%0d out3_a", id), a_o3, e[191:128]);
        chk($sformatf("v%0d out1_b", id), b_o1, e[63:0]);
        chk($sformatf("v%0d out2_b", id), b_o2, e[127:64]);
        chk($sformatf("v%0d out3_b", id), b_o3, e[191:128]);
        chk($sformatf("v%0d xor_a", id), a_o1 ^ a_o2 ^ a_o3, sbox64(v.in1 ^ v.in2 ^ v.in3));
        chk($sformatf("v%0d xor_b", id), b_o1 ^ b_o2 ^ b_o3, sbox64(v.in1 ^ v.in2 ^ v.in3));
        prev1 = e[63:0];
    endtask

    initial begin
        logic [191:0] e;
        for (int i = 0; i < NV; i++) begin
            vt[i].in1    = {$urandom, $urandom};
            vt[i].in2    = {$urandom, $urandom};
            vt[i].in3    = {$urandom, $urandom};
            vt[i].rnd    = {$urandom, $urandom, $urandom, $urandom};
            vt[i].inject = (i == 1);
        end
        vt[0].in1 = 64'h0123456789ABCDEF;
        vt[0].in2 = 64'hFFFF0000FFFF0000;
        vt[0].in3 = 64'h0;
        vt[2].rnd = {16{8'h3C}};
        for (int i = 0; i < NV; i++) begin
            e = run_model(vt[i].in1, vt[i].in2, vt[i].in3, vt[i].rnd);
            vt[i].e1 = e[63:0];
            vt[i].e2 = e[127:64];
            vt[i].e3 = e[191:128];
        end

        fresh = 8'h5A;
        #12;
        chk_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_zero("idle");

        for (int i = 0; i < NV; i++) run_op(vt[i], i);

        // Abort mid-operation: asynchronous reset must clear everything at once.
        @(negedge clk);
        start = 1'b1;
        in1 = {$urandom, $urandom}; in2 = {$urandom, $urandom}; in3 = {$urandom, $urandom};
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            start = 1'b0;
            fresh = 8'($urandom);
        end
        rst_n = 1'b0;
        #1;
        chk_zero("midrst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        prev1 = '0;
        lfsr_m = 8'hA5;
        for (int c = 0; c < 22; c++) begin
            @(negedge clk);
            #1;
            chk($sformatf("postrst c%0d done", c), {a_done, b_done, a_busy, b_busy}, 0);
        end
        run_op(vt[0], 99);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
